// File: rtl/llki_key_vault.sv
// llki_key_vault: LLKI discrete key receiver and holder.
// Assembles KEY_WORDS words of WORD_WIDTH bits into key_register, compares
// the completed key with EXPECTED_KEY, flags transfers attempted after the
// key is complete, and zeroizes word-by-word on clear before acknowledging.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset
//   llkid_key_data      key word (WORD_WIDTH)
//   llkid_key_valid     key word valid
//   llkid_key_ready     vault accepts a word this cycle (registered)
//   llkid_key_complete  all KEY_WORDS words loaded (registered)
//   llkid_clear_key     zeroization request
//   llkid_clear_key_ack one-cycle zeroization-done pulse (registered)
//   key_register        loaded key, word i at [WORD_WIDTH*i +: WORD_WIDTH]
//   key_match           combinational: complete and key equals EXPECTED_KEY
//   key_error           sticky overrun flag, cleared when zeroization completes
module llki_key_vault #(
    parameter int unsigned KEY_WORDS  = 1,
    parameter int unsigned WORD_WIDTH = 64,
    parameter logic [KEY_WORDS*WORD_WIDTH-1:0] EXPECTED_KEY = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WORD_WIDTH-1:0]            llkid_key_data,
    input  logic                             llkid_key_valid,
    output logic                             llkid_key_ready,
    output logic                             llkid_key_complete,
    input  logic                             llkid_clear_key,
    output logic                             llkid_clear_key_ack,
    output logic [KEY_WORDS*WORD_WIDTH-1:0]  key_register,
    output logic                             key_match,
    output logic                             key_error
);

    localparam int unsigned   PW       = $clog2(KEY_WORDS + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(KEY_WORDS - 1);
    localparam logic [PW-1:0] FULL_IDX = PW'(KEY_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPLETE,
        ST_CLEAR,
        ST_ACK
    } state_t;

    state_t                               state;
    state_t                               state_d;
    logic [PW-1:0]                        wptr;
    logic [PW-1:0]                        cidx;
    logic [KEY_WORDS-1:0][WORD_WIDTH-1:0] key_words;
    logic                                 load_en;
    logic                                 zero_en;

    // Next-state decode; clear takes priority over a simultaneous transfer.
    always_comb begin
        state_d = state;
        load_en = 1'b0;
        zero_en = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (llkid_clear_key) begin
                    state_d = ST_CLEAR;
                end else if (llkid_key_valid && llkid_key_ready) begin
                    load_en = 1'b1;
                    state_d = (wptr == LAST_IDX) ? ST_COMPLETE : ST_LOAD;
                end
            end
            ST_COMPLETE: begin
                if (llkid_clear_key) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                zero_en = 1'b1;
                if (cidx == LAST_IDX) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointers, key storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            wptr                <= '0;
            cidx                <= '0;
            key_words           <= '0;
            llkid_key_ready     <= 1'b0;
            llkid_key_complete  <= 1'b0;
            llkid_clear_key_ack <= 1'b0;
            key_error           <= 1'b0;
        end else begin
            state               <= state_d;
            // Outputs follow the state being entered so they line up with it.
            llkid_key_ready     <= (state_d == ST_IDLE) || (state_d == ST_LOAD);
            llkid_key_complete  <= (state_d == ST_COMPLETE);
            llkid_clear_key_ack <= (state_d == ST_ACK);

            if (load_en) begin
                for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                    if (PW'(i) == wptr) begin
                        key_words[i] <= llkid_key_data;
                    end
                end
            end

            if (state_d == ST_ACK) begin
                wptr <= '0;
            end else if (load_en && (wptr != FULL_IDX)) begin
                wptr <= wptr + PW'(1);
            end

            // cidx rests at zero outside ST_CLEAR, so entry always starts at word 0.
            if (zero_en) begin
                for (int unsigned i = 0; i < KEY_WORDS; i++) begin
                    if (PW'(i) == cidx) begin
                        key_words[i] <= '0;
                    end
                end
                if (cidx != FULL_IDX) begin
                    cidx <= cidx + PW'(1);
                end
            end else begin
                cidx <= '0;
            end

            if (state_d == ST_ACK) begin
                key_error <= 1'b0;
            end else if ((state == ST_COMPLETE) && llkid_key_valid) begin
                key_error <= 1'b1;
            end
        end
    end

    assign key_register = key_words;
    assign key_match    = llkid_key_complete && (key_register == EXPECTED_KEY);

endmodule

// File: tb/tb_llki_key_vault.sv
// Testbench for llki_key_vault: a 3x64 instance driven from a per-cycle
// vector table, and a 1x32 instance exercised by a short directed sequence.
module tb_llki_key_vault;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: 3 words of 64 bits, expected key {3,2,1}.
    logic          a_rst = 1'b1;
    logic [63:0]   a_data = '0;
    logic          a_valid = 1'b0;
    logic          a_ready;
    logic          a_complete;
    logic          a_clear = 1'b0;
    logic          a_ack;
    logic [191:0]  a_key;
    logic          a_match;
    logic          a_error;

    llki_key_vault #(
        .KEY_WORDS   (3),
        .WORD_WIDTH  (64),
        .EXPECTED_KEY({64'h3, 64'h2, 64'h1})
    ) dut_a (
        .clk                (clk),
        .rst                (a_rst),
        .llkid_key_data     (a_data),
        .llkid_key_valid    (a_valid),
        .llkid_key_ready    (a_ready),
        .llkid_key_complete (a_complete),
        .llkid_clear_key    (a_clear),
        .llkid_clear_key_ack(a_ack),
        .key_register       (a_key),
        .key_match          (a_match),
        .key_error          (a_error)
    );

    // Instance B: single 32-bit word.
    logic          b_rst = 1'b1;
    logic [31:0]   b_data = '0;
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic          b_complete;
    logic          b_clear = 1'b0;
    logic          b_ack;
    logic [31:0]   b_key;
    logic          b_match;
    logic          b_error;

    llki_key_vault #(
        .KEY_WORDS   (1),
        .WORD_WIDTH  (32),
        .EXPECTED_KEY(32'hCAFE_F00D)
    ) dut_b (
        .clk                (clk),
        .rst                (b_rst),
        .llkid_key_data     (b_data),
        .llkid_key_valid    (b_valid),
        .llkid_key_ready    (b_ready),
        .llkid_key_complete (b_complete),
        .llkid_clear_key    (b_clear),
        .llkid_clear_key_ack(b_ack),
        .key_register       (b_key),
        .key_match          (b_match),
        .key_error          (b_error)
    );

    typedef struct {
        bit           chk;
        bit           rst;
        bit           valid;
        bit           clear;
        logic [63:0]  data;
        bit           rdy;
        bit           cmp;
        bit           ack;
        bit           err;
        bit           mat;
        logic [191:0] key;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t v(bit chk, bit rst, bit valid, bit clear, logic [63:0] data,
                               bit rdy, bit cmp, bit ack, bit err, bit mat, logic [191:0] key);
        vec_t r;
        r.chk = chk; r.rst = rst; r.valid = valid; r.clear = clear; r.data = data;
        r.rdy = rdy; r.cmp = cmp; r.ack = ack; r.err = err; r.mat = mat; r.key = key;
        return r;
    endfunction

    function automatic logic [191:0] k(logic [63:0] w2, logic [63:0] w1, logic [63:0] w0);
        return {w2, w1, w0};
    endfunction

    task automatic check(input string name, input int idx, input logic [191:0] act,
                         input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_b(input int idx, input bit rdy, input bit cmp, input bit ack,
                           input bit err, input bit mat, input logic [31:0] key);
        check("b_ready",    idx, 192'(b_ready),    192'(rdy));
        check("b_complete", idx, 192'(b_complete), 192'(cmp));
        check("b_ack",      idx, 192'(b_ack),      192'(ack));
        check("b_error",    idx, 192'(b_error),    192'(err));
        check("b_match",    idx, 192'(b_match),    192'(mat));
        check("b_key",      idx, 192'(b_key),      192'(key));
    endtask

    initial begin
        // Step n's outputs are the values seen during that cycle, before its inputs act.
        //          chk rst val clr data         rdy cmp ack err mat key
        tab.push_back(v(0, 1, 0, 0, 64'h0,       0, 0, 0, 0, 0, '0));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(0, 0, 0)));
        // Load {3,2,1} back-to-back.
        tab.push_back(v(1, 0, 1, 0, 64'h1,       1, 0, 0, 0, 0, k(0, 0, 0)));
        tab.push_back(v(1, 0, 1, 0, 64'h2,       1, 0, 0, 0, 0, k(0, 0, 1)));
        tab.push_back(v(1, 0, 1, 0, 64'h3,       1, 0, 0, 0, 0, k(0, 2, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 1, 0, 0, 1, k(3, 2, 1)));
        // Overrun while complete.
        tab.push_back(v(1, 0, 1, 0, 64'hDEAD,    0, 1, 0, 0, 1, k(3, 2, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 1, 0, 1, 1, k(3, 2, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 1, 0, 1, 1, k(3, 2, 1)));
        // Clear from complete; clear held into ST_CLEAR and raised in ST_ACK is ignored.
        tab.push_back(v(1, 0, 0, 1, 64'h0,       0, 1, 0, 1, 1, k(3, 2, 1)));
        tab.push_back(v(1, 0, 0, 1, 64'h0,       0, 0, 0, 1, 0, k(3, 2, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 1, 0, k(3, 2, 0)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 1, 0, k(3, 0, 0)));
        tab.push_back(v(1, 0, 0, 1, 64'h0,       0, 0, 1, 0, 0, k(0, 0, 0)));
        // Reload with a wrong last word.
        tab.push_back(v(1, 0, 1, 0, 64'h1,       1, 0, 0, 0, 0, k(0, 0, 0)));
        tab.push_back(v(1, 0, 1, 0, 64'h2,       1, 0, 0, 0, 0, k(0, 0, 1)));
        tab.push_back(v(1, 0, 1, 0, 64'hF,       1, 0, 0, 0, 0, k(0, 2, 1)));
        tab.push_back(v(1, 0, 0, 1, 64'h0,       0, 1, 0, 0, 0, k(64'hF, 2, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(64'hF, 2, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(64'hF, 2, 0)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(64'hF, 0, 0)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 1, 0, 0, k(0, 0, 0)));
        // Partial load, then clear together with a transfer: that word is dropped.
        tab.push_back(v(1, 0, 1, 0, 64'h1,       1, 0, 0, 0, 0, k(0, 0, 0)));
        tab.push_back(v(1, 0, 1, 1, 64'hAA,      1, 0, 0, 0, 0, k(0, 0, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(0, 0, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(0, 0, 0)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(0, 0, 0)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 1, 0, 0, k(0, 0, 0)));
        // Load again, clear, and reset in the second cycle of ST_CLEAR.
        tab.push_back(v(1, 0, 1, 0, 64'h1,       1, 0, 0, 0, 0, k(0, 0, 0)));
        tab.push_back(v(1, 0, 1, 0, 64'h2,       1, 0, 0, 0, 0, k(0, 0, 1)));
        tab.push_back(v(1, 0, 1, 0, 64'h3,       1, 0, 0, 0, 0, k(0, 2, 1)));
        tab.push_back(v(1, 0, 0, 1, 64'h0,       0, 1, 0, 0, 1, k(3, 2, 1)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(3, 2, 1)));
        tab.push_back(v(1, 1, 0, 0, 64'h0,       0, 0, 0, 0, 0, k(3, 2, 0)));
        // Data offered before ready rises after reset is ignored.
        tab.push_back(v(1, 0, 1, 0, 64'h7,       0, 0, 0, 0, 0, k(0, 0, 0)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       1, 0, 0, 0, 0, k(0, 0, 0)));
        tab.push_back(v(1, 0, 0, 0, 64'h0,       1, 0, 0, 0, 0, k(0, 0, 0)));

        for (int i = 0; i < tab.size(); i++) begin
            @(posedge clk);
            #1;
            a_rst   = tab[i].rst;
            a_valid = tab[i].valid;
            a_clear = tab[i].clear;
            a_data  = tab[i].data;
            @(negedge clk);
            if (tab[i].chk) begin
                check("a_ready",    i, 192'(a_ready),    192'(tab[i].rdy));
                check("a_complete", i, 192'(a_complete), 192'(tab[i].cmp));
                check("a_ack",      i, 192'(a_ack),      192'(tab[i].ack));
                check("a_error",    i, 192'(a_error),    192'(tab[i].err));
                check("a_match",    i, 192'(a_match),    192'(tab[i].mat));
                check("a_key",      i, a_key,            tab[i].key);
            end
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_clear = 1'b0;

        // Single-word vault: complete one cycle after the transfer.
        b_rst = 1'b1;
        @(posedge clk); #1; b_rst = 1'b0;
        @(negedge clk); check_b(100, 0, 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1; b_valid = 1'b1; b_data = 32'hCAFE_F00D;
        @(negedge clk); check_b(101, 1, 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1; b_valid = 1'b0; b_clear = 1'b1;
        @(negedge clk); check_b(102, 0, 1, 0, 0, 1, 32'hCAFE_F00D);
        @(posedge clk); #1; b_clear = 1'b0;
        @(negedge clk); check_b(103, 0, 0, 0, 0, 0, 32'hCAFE_F00D);
        @(posedge clk); #1;
        @(negedge clk); check_b(104, 0, 0, 1, 0, 0, 32'h0);
        @(posedge clk); #1; b_valid = 1'b1; b_data = 32'h1234;
        @(negedge clk); check_b(105, 1, 0, 0, 0, 0, 32'h0);
        @(posedge clk); #1; b_valid = 1'b1; b_data = 32'h5555;
        @(negedge clk); check_b(106, 0, 1, 0, 0, 0, 32'h1234);
        @(posedge clk); #1; b_valid = 1'b0;
        @(negedge clk); check_b(107, 0, 1, 0, 1, 0, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
